// File: rtl/nco_phase_accum_pkg.sv
// Shared definitions for the NCO phase accumulator: default widths and
// FSM state encodings.
package nco_phase_accum_pkg;

    localparam int ACC_W_DEF = 16;
    localparam int OUT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } nco_state_e;

    // Number of cycles the pipeline is held off after a clear.
    localparam logic [1:0] FLUSH_CYCLES = 2'd2;

endpackage

// File: rtl/nco_acc_half.sv
// One half of the carry-pipelined phase adder: a W-bit accumulator that adds
// an addend plus carry-in when enabled and registers the carry-out.
module nco_acc_half #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] addend_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] sum_q;
    logic         cout_q;
    logic [W:0]   add_d;

    assign add_d = {1'b0, sum_q} + {1'b0, addend_i} + {{W{1'b0}}, cin_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (clr_i) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (en_i) begin
            sum_q  <= add_d[W-1:0];
            cout_q <= add_d[W];
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: rtl/nco_phase_accum.sv
// NCO phase accumulator: wrapping ACC_W-bit phase register advanced by the
// FCW through a two-stage (low half, then high half) carry-pipelined adder.
module nco_phase_accum
    import nco_phase_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] fcw_in,
    input  logic             fcw_valid,
    output logic             fcw_ready,
    input  logic             en,
    input  logic             clr,
    output logic [OUT_W-1:0] phase_out,
    output logic             phase_valid,
    output logic             wrap
);

    localparam int LO_W = ACC_W / 2;
    localparam int HI_W = ACC_W - LO_W;

    nco_state_e       state_q;
    logic [1:0]       flush_cnt_q;
    logic [ACC_W-1:0] fcw_q;

    logic             accept;
    logic             run;
    logic             clr_eff;
    logic             step;
    logic             stage2_en;

    logic             v1_q;
    logic [HI_W-1:0]  fcw_hi_q;
    logic [LO_W-1:0]  lo_sum;
    logic             c1;
    logic [HI_W-1:0]  hi_sum;
    logic             hi_cout;
    logic [LO_W-1:0]  lo_dly_q;
    logic             pvalid_q;
    logic [OUT_W-1:0] hold_q;
    logic [ACC_W-1:0] acc_full;
    logic [OUT_W-1:0] phase_cur;

    // Ready is forced low while reset is held, even though state reads IDLE.
    assign fcw_ready = ~rst & (state_q != ST_FLUSH);
    assign accept    = fcw_valid & fcw_ready;
    assign run       = (state_q == ST_RUN);
    assign clr_eff   = run & clr;
    assign step      = run & en & ~clr;
    assign stage2_en = v1_q & ~clr_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            fcw_q       <= '0;
        end else begin
            if (accept) begin
                fcw_q <= fcw_in;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= FLUSH_CYCLES - 2'd1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == 2'd0) begin
                        state_q <= ST_RUN;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage 1: low half add; snapshot the high FCW bits so a later FCW
    // update cannot leak into this step's high half.
    nco_acc_half #(.W(LO_W)) u_lo (
        .clk      (clk),
        .rst      (rst),
        .en_i     (step),
        .clr_i    (clr_eff),
        .addend_i (fcw_q[LO_W-1:0]),
        .cin_i    (1'b0),
        .sum_o    (lo_sum),
        .cout_o   (c1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            fcw_hi_q <= '0;
        end else begin
            v1_q <= step;
            if (step) begin
                fcw_hi_q <= fcw_q[ACC_W-1:LO_W];
            end
        end
    end

    // Stage 2: high half add with registered carry; advances only on a
    // stage-1 token, so gaps in en never mix carries of different steps.
    nco_acc_half #(.W(HI_W)) u_hi (
        .clk      (clk),
        .rst      (rst),
        .en_i     (stage2_en),
        .clr_i    (clr_eff),
        .addend_i (fcw_hi_q),
        .cin_i    (c1),
        .sum_o    (hi_sum),
        .cout_o   (hi_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_dly_q <= '0;
            pvalid_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            pvalid_q <= stage2_en;
            if (stage2_en) begin
                lo_dly_q <= lo_sum;
            end
            if (pvalid_q) begin
                hold_q <= phase_cur;
            end
        end
    end

    assign acc_full  = {hi_sum, lo_dly_q};
    assign phase_cur = acc_full[ACC_W-1 -: OUT_W];

    // A clear zeroes the high half, so between pulses the last emitted
    // phase is replayed from hold_q rather than the live accumulator.
    assign phase_out   = pvalid_q ? phase_cur : hold_q;
    assign phase_valid = pvalid_q;
    assign wrap        = pvalid_q & hi_cout;

endmodule

// File: tb/tb_nco_phase_accum.sv
// Directed testbench for nco_phase_accum (ACC_W=16, OUT_W=8).
module tb_nco_phase_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fcw_in;
    logic        fcw_valid;
    logic        fcw_ready;
    logic        en;
    logic        clr;
    logic [7:0]  phase_out;
    logic        phase_valid;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    nco_phase_accum #(.ACC_W(16), .OUT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .fcw_in      (fcw_in),
        .fcw_valid   (fcw_valid),
        .fcw_ready   (fcw_ready),
        .en          (en),
        .clr         (clr),
        .phase_out   (phase_out),
        .phase_valid (phase_valid),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] p, input logic w);
        chk({tag, "_valid"}, {31'd0, phase_valid}, {31'd0, v});
        chk({tag, "_phase"}, {24'd0, phase_out}, {24'd0, p});
        chk({tag, "_wrap"}, {31'd0, wrap}, {31'd0, w});
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        fcw_valid = 1'b0;
        fcw_in    = 16'h0000;
        en        = 1'b0;
        clr       = 1'b0;
        tick();
        tick();
        chk({tag, "_rst_ready"}, {31'd0, fcw_ready}, 32'd0);
        chk_out({tag, "_rst"}, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        #1;
    endtask

    task automatic load_fcw(input string tag, input logic [15:0] f);
        fcw_valid = 1'b1;
        fcw_in    = f;
        chk({tag, "_ready"}, {31'd0, fcw_ready}, 32'd1);
        tick();
        fcw_valid = 1'b0;
    endtask

    initial begin
        // Reset state and clr in IDLE being a no-op
        do_reset("t0");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t0_idle_clr_ready", {31'd0, fcw_ready}, 32'd1);
        chk_out("t0_idle_clr", 1'b0, 8'h00, 1'b0);

        // Test 1: FCW=0x0100, four steps
        do_reset("t1");
        load_fcw("t1", 16'h0100);
        en = 1'b1;
        tick(); chk_out("t1_s1", 1'b0, 8'h00, 1'b0);
        tick(); chk_out("t1_p1", 1'b1, 8'h01, 1'b0);
        tick(); chk_out("t1_p2", 1'b1, 8'h02, 1'b0);
        tick(); chk_out("t1_p3", 1'b1, 8'h03, 1'b0);
        en = 1'b0;
        tick(); chk_out("t1_p4", 1'b1, 8'h04, 1'b0);
        tick(); chk_out("t1_hold", 1'b0, 8'h04, 1'b0);

        // Test 2: FCW=0x00FF, low-to-high carry
        do_reset("t2");
        load_fcw("t2", 16'h00FF);
        en = 1'b1;
        tick(); chk_out("t2_s1", 1'b0, 8'h00, 1'b0);
        tick(); chk_out("t2_p1", 1'b1, 8'h00, 1'b0);
        tick(); chk_out("t2_p2", 1'b1, 8'h01, 1'b0);
        en = 1'b0;
        tick(); chk_out("t2_p3", 1'b1, 8'h02, 1'b0);

        // Test 3: FCW=0x8000, overflow on second step
        do_reset("t3");
        load_fcw("t3", 16'h8000);
        en = 1'b1;
        tick(); chk_out("t3_s1", 1'b0, 8'h00, 1'b0);
        tick(); chk_out("t3_p1", 1'b1, 8'h80, 1'b0);
        en = 1'b0;
        tick(); chk_out("t3_p2", 1'b1, 8'h00, 1'b1);
        tick(); chk_out("t3_hold", 1'b0, 8'h00, 1'b0);

        // Test 4: FCW=0x0180 with en pattern 1,0,0,1
        do_reset("t4");
        load_fcw("t4", 16'h0180);
        en = 1'b1;
        tick(); chk_out("t4_s1", 1'b0, 8'h00, 1'b0);
        en = 1'b0;
        tick(); chk_out("t4_p1", 1'b1, 8'h01, 1'b0);
        tick(); chk_out("t4_gap", 1'b0, 8'h01, 1'b0);
        en = 1'b1;
        tick(); chk_out("t4_s2", 1'b0, 8'h01, 1'b0);
        en = 1'b0;
        tick(); chk_out("t4_p2", 1'b1, 8'h03, 1'b0);
        tick(); chk_out("t4_hold", 1'b0, 8'h03, 1'b0);

        // Test 5: clear with a step in flight and a new FCW offered
        do_reset("t5");
        load_fcw("t5", 16'h0100);
        en = 1'b1;
        tick(); chk_out("t5_s1", 1'b0, 8'h00, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            tick();
            chk_out($sformatf("t5_p%0d", i - 1), 1'b1, 8'(i - 1), 1'b0);
        end
        clr       = 1'b1;
        fcw_valid = 1'b1;
        fcw_in    = 16'h0200;
        chk("t5_ready_clr", {31'd0, fcw_ready}, 32'd1);
        tick();
        clr       = 1'b0;
        fcw_valid = 1'b0;
        chk("t5_ready_f1", {31'd0, fcw_ready}, 32'd0);
        chk_out("t5_f1", 1'b0, 8'h05, 1'b0);
        tick();
        chk("t5_ready_f2", {31'd0, fcw_ready}, 32'd0);
        chk_out("t5_f2", 1'b0, 8'h05, 1'b0);
        tick();
        chk("t5_ready_run", {31'd0, fcw_ready}, 32'd1);
        chk_out("t5_run", 1'b0, 8'h05, 1'b0);
        tick(); chk_out("t5_r1", 1'b0, 8'h05, 1'b0);
        tick(); chk_out("t5_q1", 1'b1, 8'h02, 1'b0);
        en = 1'b0;
        tick(); chk_out("t5_q2", 1'b1, 8'h04, 1'b0);
        tick(); chk_out("t5_hold", 1'b0, 8'h04, 1'b0);

        // Test 6: asynchronous reset mid-run
        do_reset("t6");
        load_fcw("t6", 16'h0100);
        en = 1'b1;
        tick();
        tick(); chk_out("t6_pre", 1'b1, 8'h01, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_ready", {31'd0, fcw_ready}, 32'd0);
        chk_out("t6_async", 1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t6_idle%0d", i), 1'b0, 8'h00, 1'b0);
        end
        chk("t6_idle_ready", {31'd0, fcw_ready}, 32'd1);
        load_fcw("t6_new", 16'h0300);
        tick(); chk_out("t6_s1", 1'b0, 8'h00, 1'b0);
        en = 1'b0;
        tick(); chk_out("t6_p1", 1'b1, 8'h03, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
